inlet_dose_sequencer: RTL
=========================

INLET_DOSE_SEQUENCER -- requirements
Module: inlet_dose_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the width of every offset, duration and timer field in cycles.
REQ-002 SHALL have parameter FLUSH_CYC, default 64, meaning the number of cycles the flush valve stays open after the last inlet closes.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid  input  1  meaning a dose program is offered.
REQ-006 SHALL have port cfg_ready  output  1  meaning the block accepts a program.
REQ-007 SHALL have port cfg_offset  input  3*CNT_W  meaning start offsets; slice i drives inlet soln(i+1).
REQ-008 SHALL have port cfg_dur  input  3*CNT_W  meaning open durations; slice i drives inlet soln(i+1).
REQ-009 SHALL have port abort  input  1  meaning stop the run and close all inlets.
REQ-010 SHALL have port valve_open  output  3  meaning inlet valve drive; bit i gates soln(i+1) into the mixer network.
REQ-011 SHALL have port flush_open  output  1  meaning the outlet flush valve drive.
REQ-012 SHALL have port busy  output  1  meaning a run is in progress.
REQ-013 SHALL have port done  output  1  meaning a one-cycle pulse when a run completes or aborts.

Function
REQ-014 SHALL implement the states IDLE, LOAD, RUN, FLUSH and DONE.
REQ-015 SHALL assert cfg_ready only in IDLE; a program is accepted when cfg_valid and cfg_ready are both high on the same cycle.
REQ-016 SHALL, on accept, register cfg_offset and cfg_dur, enter LOAD, and ignore later changes on the cfg inputs until the next accept.
REQ-017 SHALL compute end_i = offset_i + dur_i in LOAD at CNT_W+1 bits without truncation, set t_end to the maximum of the three end_i, clear timer t, and enter RUN one cycle later.
REQ-018 SHALL, in RUN, drive valve_open[i] high while offset_i <= t < end_i, as a registered output of the current t.
REQ-019 SHALL increment t (CNT_W+1 bits) by 1 each RUN cycle, and move to FLUSH on the cycle t == t_end.
REQ-020 SHALL keep valve_open[i] low for the whole run when dur_i == 0.
REQ-021 SHALL, when all three durations are zero, pass through RUN for exactly one cycle and then enter FLUSH.
REQ-022 SHALL hold flush_open high for exactly FLUSH_CYC cycles in FLUSH, with all inlet valves closed, and then enter DONE.
REQ-023 SHALL pulse done for one cycle in DONE and return to IDLE on the next cycle.
REQ-024 SHALL hold busy high in LOAD, RUN and FLUSH only.
REQ-025 SHALL, when abort is high in LOAD or RUN, force valve_open to 0 on the next cycle and enter FLUSH; abort in FLUSH restarts the flush count.
REQ-026 SHALL ignore abort in IDLE and DONE.
REQ-027 SHALL never assert flush_open and any valve_open bit in the same cycle.

Reset
REQ-028 SHALL, on rst high at any clock edge, enter IDLE with valve_open=0, flush_open=0, busy=0, done=0 and cfg_ready=1 on the following cycle, including mid-RUN or mid-FLUSH.
REQ-029 SHALL give rst priority over abort and cfg_valid.

Structure
REQ-030 SHALL place the state enumeration and the default values of CNT_W and FLUSH_CYC in the shared package mfda_ctrl_pkg.
REQ-031 SHALL instantiate three copies of one sub-module, dose_window, each holding one inlet's offset, end compare and valve register.

Verification
REQ-032 SHALL cover the staggered program offsets {soln1=40, soln2=10, soln3=0} and durations {20, 30, 50} -> valve bits open over t in [40,60), [10,40) and [0,50); FLUSH starts at t=60; done pulses exactly once.
REQ-033 SHALL cover the all-zero-duration program -> valve_open stays 0, RUN lasts 1 cycle, flush_open is high for 64 cycles, then done.
REQ-034 SHALL cover abort at t=25 in the REQ-032 program -> valve_open is 0 on the next cycle, followed by a 64-cycle flush and done.
REQ-035 SHALL cover rst at t=15 -> all outputs reach reset values on the next cycle, and a new accept succeeds immediately.
REQ-036 SHALL cover the wrap case with offset=0xFFFF and dur=0xFFFF on one inlet -> end=0x1FFFE with no overflow, and the valve opens at t=0xFFFF.
REQ-037 SHALL cover cfg_valid held high through a whole run -> exactly one accept per IDLE visit, and cfg changes during the run have no effect.

Source files
------------

// File: rtl/mfda_ctrl_pkg.sv
// Shared control definitions for the microfluidic dosing blocks.
// Holds the sequencer state encoding and the default field widths and timings.
package mfda_ctrl_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int FLUSH_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dose_window.sv
// One inlet: latches its offset/duration on accept and registers its valve.
// The valve updates one cycle after the evaluated time; no backpressure.
module dose_window
  import mfda_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] offset,
  input  logic [CNT_W-1:0] dur,
  input  logic             en,
  input  logic [CNT_W:0]   t,
  output logic [CNT_W:0]   win_end,
  output logic             active,
  output logic             valve
);

  logic [CNT_W-1:0] off_q;
  logic [CNT_W-1:0] dur_q;

  // One extra bit so offset + duration never wraps.
  assign win_end = {1'b0, off_q} + {1'b0, dur_q};
  assign active  = (dur_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      off_q <= '0;
      dur_q <= '0;
      valve <= 1'b0;
    end else begin
      if (load) begin
        off_q <= offset;
        dur_q <= dur;
      end
      valve <= en && ({1'b0, off_q} <= t) && (t < win_end);
    end
  end

endmodule

// File: rtl/inlet_dose_sequencer.sv
// Runs one three-inlet dose program: load, timed valve windows, flush, done pulse.
// Accepts a program only while idle (cfg_ready); abort cuts straight to flush.
module inlet_dose_sequencer
  import mfda_ctrl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [3*CNT_W-1:0] cfg_offset,
  input  logic [3*CNT_W-1:0] cfg_dur,
  input  logic               abort,
  output logic [2:0]         valve_open,
  output logic               flush_open,
  output logic               busy,
  output logic               done
);

  localparam int FC_W = $clog2(FLUSH_CYC + 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W:0]      t;
  logic [CNT_W:0]      t_end;
  logic [CNT_W:0]      end_max;
  logic [FC_W-1:0]     fcnt;
  logic                accept;
  logic                win_en;
  logic [CNT_W:0]      win_t;
  logic [2:0][CNT_W:0] win_end;
  logic [2:0]          active;

  assign cfg_ready  = (state == ST_IDLE);
  assign accept     = cfg_valid && cfg_ready;
  assign busy       = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_FLUSH);
  assign flush_open = (state == ST_FLUSH);
  assign done       = (state == ST_DONE);

  for (genvar i = 0; i < 3; i++) begin : g_win
    dose_window #(
      .CNT_W(CNT_W)
    ) u_win (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .offset (cfg_offset[i*CNT_W +: CNT_W]),
      .dur    (cfg_dur[i*CNT_W +: CNT_W]),
      .en     (win_en),
      .t      (win_t),
      .win_end(win_end[i]),
      .active (active[i]),
      .valve  (valve_open[i])
    );
  end

  always_comb begin
    end_max = win_end[0];
    if (win_end[1] > end_max) end_max = win_end[1];
    if (win_end[2] > end_max) end_max = win_end[2];
  end

  // Windows are fed the time of the coming cycle so valve_open lines up with t.
  always_comb begin
    state_nxt = state;
    win_en    = 1'b0;
    win_t     = t + 1'b1;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        win_t = '0;
        if (abort) begin
          state_nxt = ST_FLUSH;
        end else begin
          state_nxt = ST_RUN;
          win_en    = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort || (t == t_end)) state_nxt = ST_FLUSH;
        else                       win_en    = 1'b1;
      end
      ST_FLUSH: begin
        if (!abort && (fcnt == FC_W'(FLUSH_CYC - 1))) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      t     <= '0;
      t_end <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      // With every duration zero the run is a single pass at t = 0.
      if (state == ST_LOAD) begin
        t     <= '0;
        t_end <= (|active) ? end_max : '0;
      end else if (state == ST_RUN) begin
        t <= t + 1'b1;
      end
      if ((state_nxt == ST_FLUSH) && ((state != ST_FLUSH) || abort)) fcnt <= '0;
      else if (state == ST_FLUSH)                                    fcnt <= fcnt + 1'b1;
    end
  end

endmodule
